// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the AXI-lite master bridge.
// Holds the FSM state encoding, the AXI response code and the data/strobe widths.
// No logic; imported by the bridge top.
package axi_bridge_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding bridge from the core request/response port to an AXI-lite master.
// Latency: accept at cycle 0, resp_valid at cycle 4 with a zero-wait slave.
// Backpressure: req_ready is high only when idle; AXI valids hold until their handshake.
// Optional watchdog: define AXI_BRIDGE_TIMEOUT_EN to bound every AXI wait by TIMEOUT_CYC.
module axi_lite_master_bridge
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t state;

  // A write channel counts as done once its valid has dropped or it handshakes this cycle.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

`ifdef AXI_BRIDGE_TIMEOUT_EN
  // Watchdog: counts cycles spent in the current AXI wait state.
  logic [15:0] wd_cnt;
  state_t      wd_state;
  logic [15:0] wd_elapsed;
  logic        wd_busy;
  logic        wd_hit;

  assign wd_busy    = (state == S_AR) || (state == S_R) || (state == S_WR) || (state == S_B);
  assign wd_elapsed = (state == wd_state) ? wd_cnt : 16'd0;
  // Fires two cycles early so that resp_valid lands TIMEOUT_CYC cycles after state entry.
  assign wd_hit     = wd_busy && (wd_elapsed == 16'(TIMEOUT_CYC - 2));

  // Track the state and restart the count whenever the state changes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_cnt   <= '0;
      wd_state <= S_IDLE;
    end else begin
      wd_state <= state;
      wd_cnt   <= wd_busy ? wd_elapsed + 16'd1 : 16'd0;
    end
  end
`endif

  // Transaction FSM; every AXI and response output is registered here.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_we) begin
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_err   <= (rresp != RESP_OKAY);
            state      <= S_RESP;
          end
        end
        S_WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready   <= 1'b0;
            resp_err <= (bresp != RESP_OKAY);
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          // First RESP cycle raises the pulse; second drops it and reopens the request port.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef AXI_BRIDGE_TIMEOUT_EN
      // Watchdog overrides the FSM: abandon the transfer and report an error.
      if (wd_hit) begin
        arvalid    <= 1'b0;
        rready     <= 1'b0;
        awvalid    <= 1'b0;
        wvalid     <= 1'b0;
        bready     <= 1'b0;
        resp_err   <= 1'b1;
        resp_rdata <= '0;
        state      <= S_RESP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge with a small reactive AXI-lite slave.
// Vectors cover reads, writes, error responses and a slow W channel; hand sequences
// cover a stalled AR channel and an asynchronous reset in the middle of a read.
module tb_axi_lite_master_bridge;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  int checks = 0;
  int errors = 0;

  axi_lite_master_bridge #(.ADDR_W(32), .TIMEOUT_CYC(255)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  // Slave configuration and observations
  int          ar_lat = 0;
  int          w_lat = 0;
  logic        ar_hold = 1'b0;
  logic        r_hold = 1'b0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_resp = '0;
  int          ar_cnt = 0;
  int          w_cnt = 0;
  logic [31:0] seen_addr = '0;
  logic [63:0] seen_wdata = '0;
  logic [7:0]  seen_wstrb = '0;
  logic        aw_first = 1'b0;

  // Reactive slave: drives its inputs mid-cycle from the bridge's registered outputs.
  always @(negedge aclk) begin
    arready = arvalid && !ar_hold && (ar_cnt >= ar_lat);
    ar_cnt  = (arvalid && !arready) ? ar_cnt + 1 : 0;
    if (arvalid && arready) seen_addr = araddr;
    awready = awvalid;
    if (awvalid && awready) seen_addr = awaddr;
    wready = wvalid && (w_cnt >= w_lat);
    w_cnt  = (wvalid && !wready) ? w_cnt + 1 : 0;
    if (wvalid && wready) begin
      seen_wdata = wdata;
      seen_wstrb = wstrb;
    end
    if (!awvalid && wvalid) aw_first = 1'b1;
    rvalid = rready && !r_hold;
    rdata  = cfg_rdata;
    rresp  = cfg_resp;
    bvalid = bready;
    bresp  = cfg_resp;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  ws;
    int          arl;
    int          wl;
    logic [63:0] rd;
    logic [1:0]  rsp;
    int          exp_lat;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // Issue one request at the next negedge; returns the cycle index of resp_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] ws, output int lat);
    @(negedge aclk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge aclk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{1'b0, 32'h0000_1000, 64'h0, 8'h00, 0, 0, 64'h1122334455667788, 2'b00,
                4, 64'h1122334455667788, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_2000, 64'hDEADBEEF00000000, 8'hF0, 0, 3, 64'h0, 2'b00,
                7, 64'h1122334455667788, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_3008, 64'h0, 8'h00, 0, 0, 64'hAAAA5555CCCC3333, 2'b10,
                4, 64'hAAAA5555CCCC3333, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_3010, 64'h0, 8'h00, 0, 0, 64'h0123456789ABCDEF, 2'b00,
                4, 64'h0123456789ABCDEF, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0040, 64'h5555666677778888, 8'h0F, 0, 0, 64'h0, 2'b11,
                4, 64'h0123456789ABCDEF, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0080, 64'h0, 8'h00, 2, 0, 64'hFEDCBA9876543210, 2'b00,
                6, 64'hFEDCBA9876543210, 1'b0};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_addr", {araddr, awaddr}, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      ar_lat    = vecs[i].arl;
      w_lat     = vecs[i].wl;
      cfg_rdata = vecs[i].rd;
      cfg_resp  = vecs[i].rsp;
      aw_first  = 1'b0;
      issue(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].ws, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), resp_err, vecs[i].exp_err);
      check($sformatf("v%0d_ready_in_resp", i), req_ready, 0);
      check($sformatf("v%0d_addr", i), seen_addr, vecs[i].addr);
      if (vecs[i].we) begin
        check($sformatf("v%0d_wdata", i), seen_wdata, vecs[i].wd);
        check($sformatf("v%0d_wstrb", i), seen_wstrb, vecs[i].ws);
        check($sformatf("v%0d_aw_first", i), aw_first, (vecs[i].wl > 0));
      end
      @(posedge aclk);
      #1;
      check($sformatf("v%0d_pulse_end", i), resp_valid, 0);
      check($sformatf("v%0d_ready_back", i), req_ready, 1);
    end

    // AR channel stalled for 10 cycles
    ar_lat    = 0;
    ar_hold   = 1'b1;
    cfg_rdata = 64'h0F0F0F0F0F0F0F0F;
    cfg_resp  = 2'b00;
    @(negedge aclk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_5A50;
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("stall%0d", k),
            {araddr, 28'h0, arvalid, req_ready, resp_valid, awvalid},
            {32'h0000_5A50, 28'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      if (k < 10) begin
        @(posedge aclk);
        #1;
      end
    end
    ar_hold = 1'b0;
    lat = 10;
    while (!resp_valid && lat < 200) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    check("stall_latency", 64'(lat), 64'd13);
    check("stall_rdata", resp_rdata, 64'h0F0F0F0F0F0F0F0F);
    @(posedge aclk);
    #1;

    // Asynchronous reset while waiting in R
    r_hold    = 1'b1;
    cfg_rdata = 64'h1234123412341234;
    @(negedge aclk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_7000;
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rready && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    check("mid_r_rready", rready, 1);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    check("arst_rdata", resp_rdata, 0);
    @(negedge aclk);
    areset = 1'b0;
    r_hold = 1'b0;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge aclk);
      #1;
      if (resp_valid) lat++;
    end
    check("arst_no_spurious_resp", 64'(lat), 0);
    check("arst_idle_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
